// File: rtl/even_parity_pkg.sv
// even_parity_pkg -- shared types and constants for the even-parity serial
// transmitter. Configuration macro: EVEN_PARITY_TX_START_BIT_EN (when
// defined, every frame is preceded by a single start bit and the START
// state is part of the state enumeration).
package even_parity_pkg;

  // Payload width used when the parent does not override DATA_W.
  localparam int DEFAULT_DATA_W = 8;

  // Level driven on the serial line during the START cycle.
  localparam logic START_BIT_VAL = 1'b0;

`ifdef EVEN_PARITY_TX_START_BIT_EN
  // Transmitter states; each state names what is currently on the line.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_DATA   = 2'd2,
    ST_PARITY = 2'd3
  } tx_state_e;

  // Number of line cycles a single frame occupies.
  function automatic int frame_len(input int data_w);
    return data_w + 2;
  endfunction
`else
  // Transmitter states; each state names what is currently on the line.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd2,
    ST_PARITY = 2'd3
  } tx_state_e;

  // Number of line cycles a single frame occupies.
  function automatic int frame_len(input int data_w);
    return data_w + 1;
  endfunction
`endif

endpackage : even_parity_pkg

// File: rtl/even_parity_tx_piso_shift.sv
// piso_shift -- parallel-in / serial-out shift register with an LSB tap.
// Load takes priority over shift; shifting moves toward bit 0 and fills the
// MSB with zero, so the tap presents successive bits LSB first.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         lsb_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  // Next-state: load a fresh word, shift one place, or hold.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = {1'b0, sr_q[W-1:1]};
    end
  end

  // Register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign lsb_o = sr_q[0];

endmodule : piso_shift

// File: rtl/even_parity_tx.sv
// even_parity_tx -- serialises DATA_W-bit words LSB first, followed by an
// even-parity bit. Configuration macro: EVEN_PARITY_TX_START_BIT_EN (adds a
// one-cycle start bit ahead of the data bits).
//
// The serial output is a flop. The shift register therefore always runs one
// bit ahead of the line: while bit k is on x, its LSB tap holds bit k+1, so
// the next line value is available without extra muxing.
module even_parity_tx
  import even_parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              x,
  output logic              frame,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             par_q;
  logic             par_d;
  logic             x_q;
  logic             x_d;

  logic              accept;
  logic              sr_load;
  logic              sr_shift;
  logic              sr_lsb;
  logic [DATA_W-1:0] sr_load_val;

  assign accept = valid_in & ready_out;

`ifdef EVEN_PARITY_TX_START_BIT_EN
  // The START cycle performs the first shift, so load the whole word.
  assign sr_load_val = data_in;
`else
  // Bit 0 goes straight to the line on accept; keep the rest one ahead.
  assign sr_load_val = data_in >> 1;
`endif

  piso_shift #(
    .W (DATA_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .din_i   (sr_load_val),
    .lsb_o   (sr_lsb)
  );

  // Next-state, next line bit, counter and parity accumulator.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    x_d      = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;

    case (state_q)
      ST_IDLE, ST_PARITY: begin
        if (accept) begin
          sr_load = 1'b1;
          cnt_d   = '0;
          par_d   = 1'b0;
`ifdef EVEN_PARITY_TX_START_BIT_EN
          state_d = ST_START;
          x_d     = START_BIT_VAL;
`else
          state_d = ST_DATA;
          x_d     = data_in[0];
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

`ifdef EVEN_PARITY_TX_START_BIT_EN
      ST_START: begin
        sr_shift = 1'b1;
        x_d      = sr_lsb;
        state_d  = ST_DATA;
      end
`endif

      ST_DATA: begin
        // Fold the bit currently on the line into the running parity.
        par_d = par_q ^ x_q;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_PARITY;
          x_d     = par_q ^ x_q;
        end else begin
          sr_shift = 1'b1;
          x_d      = sr_lsb;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, parity and line registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      x_q     <= x_d;
    end
  end

  // Status outputs decode the registered state only.
  assign ready_out = (state_q == ST_IDLE) || (state_q == ST_PARITY);
  assign frame     = (state_q != ST_IDLE);
  assign done      = (state_q == ST_PARITY);
  assign x         = x_q;

endmodule : even_parity_tx

// File: tb/tb_even_parity_tx.sv
// tb_even_parity_tx -- self-checking bench for even_parity_tx (DATA_W=8).
// Honours EVEN_PARITY_TX_START_BIT_EN the same way the design does.
module tb_even_parity_tx;

  localparam int DATA_W = 8;
`ifdef EVEN_PARITY_TX_START_BIT_EN
  localparam bit START_EN = 1'b1;
`else
  localparam bit START_EN = 1'b0;
`endif
  localparam int FLEN = DATA_W + 1 + (START_EN ? 1 : 0);

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic              x;
  logic              frame;
  logic              done;

  even_parity_tx #(
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .x         (x),
    .frame     (frame),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic x;
    logic f;
    logic d;
  } line_t;

  // Line values still to be emitted by frames already accepted.
  line_t mq[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int ones         = 0;
  int run_len      = 0;
  int max_run      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered and left on the falling edge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d);
    logic  exp_ready;
    logic  acc;
    line_t cur;
    valid_in  = v;
    data_in   = d;
    exp_ready = (mq.size() == 0);
    #1;
    check("ready", ready_out, exp_ready);
    acc = v && exp_ready;
    @(posedge clk);
    if (acc) begin
      if (START_EN) mq.push_back('{x: 1'b0, f: 1'b1, d: 1'b0});
      for (int i = 0; i < DATA_W; i++) mq.push_back('{x: d[i], f: 1'b1, d: 1'b0});
      mq.push_back('{x: ^d, f: 1'b1, d: 1'b1});
    end
    if (mq.size() > 0) cur = mq.pop_front();
    else cur = '{x: 1'b0, f: 1'b0, d: 1'b0};
    #1;
    check("x", x, cur.x);
    check("frame", frame, cur.f);
    check("done", done, cur.d);
    // Independent even-ones checker on the serial line.
    if (frame) ones += int'(x);
    if (done) begin
      check("even_ones", ones % 2, 0);
      ones = 0;
    end
    if (frame) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    @(negedge clk);
  endtask

  // Pulse reset in the middle of a cycle and confirm the asynchronous clear.
  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    check("rst_x", x, 0);
    check("rst_frame", frame, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready_out, 1);
    mq.delete();
    ones    = 0;
    run_len = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    #1;
    check("reset_x", x, 0);
    check("reset_frame", frame, 0);
    check("reset_done", done, 0);
    check("reset_ready", ready_out, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single frame of 8'hA5.
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < FLEN + 2; i++) cycle(1'b0, 8'h00);

    // Single frame of 8'h07 (odd payload ones, parity 1).
    cycle(1'b1, 8'h07);
    for (int i = 0; i < FLEN + 2; i++) cycle(1'b0, 8'h00);

    // Back-to-back frames with valid held high.
    max_run = 0;
    cycle(1'b1, 8'hFF);
    for (int i = 0; i < FLEN - 1; i++) cycle(1'b1, 8'h01);
    cycle(1'b1, 8'h01);
    for (int i = 0; i < FLEN + 2; i++) cycle(1'b0, 8'h00);
    check("b2b_run", max_run, 2 * FLEN);

    // Reset during data bit 3 of 8'h5A, then a fresh 8'h00 frame.
    cycle(1'b1, 8'h5A);
    for (int i = 0; i < 3 + (START_EN ? 1 : 0); i++) cycle(1'b0, 8'h00);
    mid_reset();
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h00);
    for (int i = 0; i < FLEN + 2; i++) cycle(1'b0, 8'h00);

    // valid pulse with 8'h33 during the data of 8'hA5 must be ignored.
    cycle(1'b1, 8'hA5);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h33);
    for (int i = 0; i < FLEN + 2; i++) cycle(1'b0, 8'h33);
    check("idle_after_ignore", frame, 0);

    // Randomised traffic with occasional mid-cycle resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) mid_reset();
      else cycle(($urandom_range(0, 2) != 0), DATA_W'($urandom));
    end
    for (int i = 0; i < FLEN + 2; i++) cycle(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_even_parity_tx

// File: doc/even_parity_tx.md
EVEN_PARITY_TX -- requirements
Module: even_parity_tx

Interface
REQ-001 Parameter DATA_W, default 8, number of payload bits per frame (legal range 2..32).
REQ-002 The block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-low reset; low forces reset state immediately.
REQ-005 data_in  input  DATA_W  parallel payload word.
REQ-006 valid_in  input  1  payload word offered this cycle.
REQ-007 ready_out  output  1  block can accept a word this cycle.
REQ-008 x  output  1  registered serial bit stream.
REQ-009 frame  output  1  high while x carries a frame bit (start, data or parity).
REQ-010 done  output  1  one-cycle pulse in the cycle the parity bit is on x.

Function
REQ-011 States SHALL be IDLE, START (macro only), DATA and PARITY.
REQ-012 A word SHALL be accepted on a rising edge where valid_in=1 and ready_out=1; data_in is captured into a shift register and the parity accumulator is cleared.
REQ-013 ready_out SHALL be 1 in IDLE and in PARITY, and 0 in START and DATA.
REQ-014 The first frame bit SHALL appear on x in the cycle after acceptance (latency 1).
REQ-015 Data SHALL be sent LSB first, one bit per cycle, for exactly DATA_W cycles, with a bit counter width of clog2(DATA_W).
REQ-016 The parity bit SHALL equal the XOR of all DATA_W payload bits, so each frame's data+parity carries an even count of ones.
REQ-017 Transitions SHALL be: IDLE -accept-> START or DATA; START -> DATA; DATA -> DATA until the last bit, then -> PARITY; PARITY -accept-> START or DATA (back-to-back, no idle gap); PARITY -no accept-> IDLE.
REQ-018 In IDLE, x, frame and done SHALL be 0.
REQ-019 valid_in while ready_out=0 SHALL be ignored, and data_in changes mid-frame SHALL NOT affect the frame in flight.
REQ-020 done SHALL be 1 only while in PARITY state.

Reset
REQ-021 While rst=0: state=IDLE, x=0, frame=0, done=0, ready_out=1, shift register, counter and parity accumulator = 0.
REQ-022 Reset mid-frame SHALL abort the frame with no parity bit and no done pulse; the first accept after rst rises starts a fresh frame.

Configuration
REQ-023 Macro EVEN_PARITY_TX_START_BIT_EN defined: each frame SHALL begin with one START cycle driving x=0, frame=1; latency from accept to the first data bit is 2 cycles; frame length is DATA_W+2.
REQ-024 Macro undefined: no START state exists; frame length is DATA_W+1.

Structure
REQ-025 Shared package even_parity_pkg SHALL hold the state enum typedef, DEFAULT_DATA_W=8 and the start-bit value constant (0).
REQ-026 One sub-module, piso_shift (parameterized load/shift register with an LSB-out tap), SHALL be instantiated for serialization; the FSM, counter and parity accumulator live in even_parity_tx.

Verification
REQ-027 Accept 8'hA5 (no macro) -> x=1,0,1,0,0,1,0,1 then parity 0; done high on the 9th cycle after accept; ready_out back in PARITY.
REQ-028 Accept 8'h07 -> x=1,1,1,0,0,0,0,0 then parity 1; total ones on x = 4; a serial even-ones checker fed x reports even at frame end.
REQ-029 Back-to-back: valid_in held high with 8'hFF then 8'h01 -> parity 0 then 1; the second frame's first bit immediately follows the first frame's parity bit; frame stays high 18 consecutive cycles.
REQ-030 Assert rst low during data bit 3 of 8'h5A -> x, frame and done go to 0 asynchronously; no done pulse; next accept of 8'h00 yields eight 0s then parity 0.
REQ-031 With EVEN_PARITY_TX_START_BIT_EN, accept 8'h80 -> x=0 (start), 0,0,0,0,0,0,0,1, parity 1; frame high 10 cycles.
REQ-032 valid_in pulsed with 8'h33 during DATA of 8'hA5 -> ignored; only the 8'hA5 frame is emitted; the block returns to IDLE.
